regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Two-requester write-port arbiter for the 32-entry register file. Two independent write sources, A (e.g. ALU writeback) and B (e.g. load writeback), share the single register-file write port. Each source has a valid/ready handshake into a one-entry holding buffer. The block grants the port round-robin and drives a registered enable, selector and data toward the 1-to-32 write demultiplexer. Writes targeting register 0 are consumed but suppressed, so register 0 stays hardwired to zero.

## Interface
- WORD_LENGTH, 32, data width of a register-file word
- NBITS, 5, selector width (ceil log2 of register count 32)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- Valid_A  in  1  source A offers a write
- Addr_A  in  NBITS  source A destination register
- Data_A  in  WORD_LENGTH  source A write data
- Ready_A  out  1  source A handshake accept (combinational)
- Valid_B, Addr_B, Data_B, Ready_B  as for A, for source B
- Write_Enable  out  1  registered write strobe to register file
- Write_Selector  out  NBITS  registered destination, drives demux Selector
- Write_Data  out  WORD_LENGTH  registered data, drives demux input
- Dropped  out  1  registered pulse: the issued write targeted register 0 and was suppressed
- Busy  out  1  either holding buffer is full (combinational from state)

## Operation
- Per source, one holding buffer: Full_X flag, stored address, stored data. Reset: Full_X=0, contents 0.
- Handshake: transfer happens at a rising edge when Valid_X && Ready_X. Ready_X = !Full_X || Grant_X.
  - A buffer being drained this cycle can accept a new write at the same edge.
- Valid_X held high with Ready_X low keeps the request pending. The source must hold Addr_X/Data_X stable; the block does not check this.
- Grant logic is combinational from Full_A, Full_B and the Priority register:
  - only Full_A set: grant A
  - only Full_B set: grant B
  - both set: grant the side indicated by Priority (0 = A, 1 = B)
  - neither set: no grant
- Priority register, reset 0:
  - after a grant to A, set to 1
  - after a grant to B, set to 0
  - unchanged when idle
- On the edge where Grant_X is active:
  - Full_X clears, unless a new transfer is accepted into X at the same edge, in which case it stays 1 with the new contents
  - Write_Selector and Write_Data load the granted address and data
  - Write_Enable loads 1 if the granted address != 0; otherwise it loads 0 and Dropped loads 1
- With no grant, Write_Enable and Dropped load 0. Write_Selector and Write_Data hold their last values.
- Ordering: writes from one source issue in acceptance order. Between sources, order follows grant order only. When A and B target the same register in consecutive grants, the later grant wins in the register file.

## Timing
- Reset values: Write_Enable=0, Write_Selector=0, Write_Data=0, Dropped=0, Busy=0, Ready_A=Ready_B=1, Priority=0.
- Reset is asynchronous. Asserting it mid-operation discards buffered writes immediately. Any write already presented on the outputs is cancelled (Write_Enable forced 0). No write is issued until reset deasserts.
- Latency: a write accepted at edge t into an empty buffer, with no contention, appears on Write_Enable/Selector/Data during the cycle after edge t+1, i.e. 2 edges from acceptance.
- Throughput:
  - single active source: one write per cycle, back-to-back, Ready stays high
  - both sources continuously valid: alternate A,B,A,B; each source's Ready is high every other cycle
- Simultaneous first requests from both sources with Priority=0: A is issued first, B one cycle later.
- Write_Enable is a one-cycle pulse per issued write. Consecutive issues give Write_Enable high on consecutive cycles.

## Test plan
- Reset check: assert reset mid-stream with both buffers full. All outputs return to their reset values without waiting for a clock edge, and no Write_Enable appears after release until new requests arrive.
- Single source: A streams Addr 1..4 with Data 0x11..0x44 on consecutive cycles. Write_Enable is high 4 consecutive cycles, starting 2 edges after the first accept, with Selector 1,2,3,4 and matching data. Ready_A never drops.
- Contention: A and B valid continuously from reset (A: addr 5, data 0xA0+n; B: addr 6, data 0xB0+n). Issue order is A,B,A,B. Each Ready alternates high/low, and no write is lost or duplicated over 20 cycles.
- Same-register race: A writes 0xAAAA_AAAA to r7 and B writes 0xBBBB_BBBB to r7, both accepted at the same edge with Priority=0. The issue order is A then B, so the final value presented last to r7 is 0xBBBB_BBBB.
- Register 0 suppression: B writes 0xDEAD_BEEF to addr 0. A Dropped pulse of 1 cycle occurs, Write_Enable stays 0, and Busy clears afterwards.
- Backpressure hold: A valid and blocked while B holds priority. Addr_A/Data_A held stable, Ready_A low for exactly one cycle. The write is issued intact on the next grant, and Priority toggles per grant as specified.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the two writeback sources and the register-file write arbiter.
// The master side offers writes; the slave side (the arbiter) accepts them and drives the port.
interface regfile_write_arbiter_if #(
  parameter int WORD_LENGTH = 32,
  parameter int NBITS       = 5
);
  logic                   Valid_A;
  logic [NBITS-1:0]       Addr_A;
  logic [WORD_LENGTH-1:0] Data_A;
  logic                   Ready_A;
  logic                   Valid_B;
  logic [NBITS-1:0]       Addr_B;
  logic [WORD_LENGTH-1:0] Data_B;
  logic                   Ready_B;
  logic                   Write_Enable;
  logic [NBITS-1:0]       Write_Selector;
  logic [WORD_LENGTH-1:0] Write_Data;
  logic                   Dropped;
  logic                   Busy;

  modport master (
    output Valid_A, Addr_A, Data_A, Valid_B, Addr_B, Data_B,
    input  Ready_A, Ready_B, Write_Enable, Write_Selector, Write_Data, Dropped, Busy
  );

  modport slave (
    input  Valid_A, Addr_A, Data_A, Valid_B, Addr_B, Data_B,
    output Ready_A, Ready_B, Write_Enable, Write_Selector, Write_Data, Dropped, Busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between sources A and B.
// Each source has a one-entry holding buffer; writes to register 0 are consumed and suppressed.
module regfile_write_arbiter #(
  parameter int WORD_LENGTH = 32,
  parameter int NBITS       = 5
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  typedef struct packed {
    logic                   full;
    logic [NBITS-1:0]       addr;
    logic [WORD_LENGTH-1:0] data;
  } hold_t;

  hold_t                  hold_a_q, hold_a_d;
  hold_t                  hold_b_q, hold_b_d;
  logic                   prio_q, prio_d;
  logic                   write_enable_q, write_enable_d;
  logic [NBITS-1:0]       write_selector_q, write_selector_d;
  logic [WORD_LENGTH-1:0] write_data_q, write_data_d;
  logic                   dropped_q, dropped_d;

  logic                   grant_a, grant_b;
  logic                   ready_a, ready_b;
  logic                   accept_a, accept_b;
  logic [NBITS-1:0]       grant_addr;
  logic [WORD_LENGTH-1:0] grant_data;

  // Priority only matters when both buffers hold a write.
  always_comb begin
    grant_a  = hold_a_q.full && (!hold_b_q.full || !prio_q);
    grant_b  = hold_b_q.full && (!hold_a_q.full ||  prio_q);
    ready_a  = !hold_a_q.full || grant_a;
    ready_b  = !hold_b_q.full || grant_b;
    accept_a = bus.Valid_A && ready_a;
    accept_b = bus.Valid_B && ready_b;
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path through this block infers a latch.
    hold_a_d         = hold_a_q;
    hold_b_d         = hold_b_q;
    prio_d           = prio_q;
    write_enable_d   = 1'b0;
    dropped_d        = 1'b0;
    write_selector_d = write_selector_q;
    write_data_d     = write_data_q;
    grant_addr       = grant_a ? hold_a_q.addr : hold_b_q.addr;
    grant_data       = grant_a ? hold_a_q.data : hold_b_q.data;

    if (grant_a) hold_a_d.full = 1'b0;
    if (grant_b) hold_b_d.full = 1'b0;

    // A buffer drained this edge may refill at the same edge.
    if (accept_a) begin
      hold_a_d.full = 1'b1;
      hold_a_d.addr = bus.Addr_A;
      hold_a_d.data = bus.Data_A;
    end
    if (accept_b) begin
      hold_b_d.full = 1'b1;
      hold_b_d.addr = bus.Addr_B;
      hold_b_d.data = bus.Data_B;
    end

    if (grant_a)      prio_d = 1'b1;
    else if (grant_b) prio_d = 1'b0;

    if (grant_a || grant_b) begin
      write_selector_d = grant_addr;
      write_data_d     = grant_data;
      write_enable_d   = |grant_addr;
      dropped_d        = ~|grant_addr;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_a_q         <= '0;
      hold_b_q         <= '0;
      prio_q           <= 1'b0;
      write_enable_q   <= 1'b0;
      write_selector_q <= '0;
      write_data_q     <= '0;
      dropped_q        <= 1'b0;
    end else begin
      hold_a_q         <= hold_a_d;
      hold_b_q         <= hold_b_d;
      prio_q           <= prio_d;
      write_enable_q   <= write_enable_d;
      write_selector_q <= write_selector_d;
      write_data_q     <= write_data_d;
      dropped_q        <= dropped_d;
    end
  end

  assign bus.Ready_A        = ready_a;
  assign bus.Ready_B        = ready_b;
  assign bus.Write_Enable   = write_enable_q;
  assign bus.Write_Selector = write_selector_q;
  assign bus.Write_Data     = write_data_q;
  assign bus.Dropped        = dropped_q;
  assign bus.Busy           = hold_a_q.full || hold_b_q.full;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of the two sources and the round-robin turn.
module tb_regfile_write_arbiter;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  regfile_write_arbiter_if #(.WORD_LENGTH(32), .NBITS(5)) bus ();

  regfile_write_arbiter #(.WORD_LENGTH(32), .NBITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state.
  wr_t         qa[$];
  wr_t         qb[$];
  bit          m_turn_b;
  logic        m_we, m_drop;
  logic [4:0]  m_sel;
  logic [31:0] m_data;
  logic [31:0] m_rf[32];
  logic [31:0] o_rf[32];
  bit          acc_a, acc_b;
  int          ready_a_low;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_turn_b = 1'b0;
    m_we     = 1'b0;
    m_drop   = 1'b0;
    m_sel    = '0;
    m_data   = '0;
    acc_a    = 1'b0;
    acc_b    = 1'b0;
  endtask

  task automatic model_issue(input wr_t w);
    m_sel  = w.addr;
    m_data = w.data;
    m_we   = (w.addr != 0);
    m_drop = (w.addr == 0);
    if (w.addr != 0) m_rf[w.addr] = w.data;
  endtask

  // One clock: check everything mid-cycle, then advance the model on the rising edge.
  task automatic cycle();
    bit  ga, gb, ra, rb;
    wr_t w;
    @(negedge clk);
    ga = (qa.size() != 0) && ((qb.size() == 0) || !m_turn_b);
    gb = (qb.size() != 0) && ((qa.size() == 0) ||  m_turn_b);
    ra = (qa.size() == 0) || ga;
    rb = (qb.size() == 0) || gb;
    check("ready_a",  64'(bus.Ready_A), 64'(ra));
    check("ready_b",  64'(bus.Ready_B), 64'(rb));
    check("busy",     64'(bus.Busy), 64'((qa.size() != 0) || (qb.size() != 0)));
    check("we",       64'(bus.Write_Enable), 64'(m_we));
    check("dropped",  64'(bus.Dropped), 64'(m_drop));
    check("selector", 64'(bus.Write_Selector), 64'(m_sel));
    check("data",     64'(bus.Write_Data), 64'(m_data));
    if (!bus.Ready_A) ready_a_low++;
    if (bus.Write_Enable) o_rf[bus.Write_Selector] = bus.Write_Data;
    @(posedge clk);
    acc_a = bus.Valid_A && ra;
    acc_b = bus.Valid_B && rb;
    if (ga) begin
      w = qa.pop_front();
      model_issue(w);
      m_turn_b = 1'b1;
    end else if (gb) begin
      w = qb.pop_front();
      model_issue(w);
      m_turn_b = 1'b0;
    end else begin
      m_we   = 1'b0;
      m_drop = 1'b0;
    end
    if (acc_a) qa.push_back('{addr: bus.Addr_A, data: bus.Data_A});
    if (acc_b) qb.push_back('{addr: bus.Addr_B, data: bus.Data_B});
    #1;
  endtask

  task automatic idle(input int n);
    bus.Valid_A = 1'b0;
    bus.Valid_B = 1'b0;
    repeat (n) cycle();
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_we",       64'(bus.Write_Enable), 64'd0);
    check("rst_selector", 64'(bus.Write_Selector), 64'd0);
    check("rst_data",     64'(bus.Write_Data), 64'd0);
    check("rst_dropped",  64'(bus.Dropped), 64'd0);
    check("rst_busy",     64'(bus.Busy), 64'd0);
    check("rst_ready_a",  64'(bus.Ready_A), 64'd1);
    check("rst_ready_b",  64'(bus.Ready_B), 64'd1);
    @(posedge clk);
    #1;
    bus.Valid_A = 1'b0;
    bus.Valid_B = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int na, nb;
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = '0;
      o_rf[i] = '0;
    end
    bus.Valid_A = 1'b0;
    bus.Addr_A  = '0;
    bus.Data_A  = '0;
    bus.Valid_B = 1'b0;
    bus.Addr_B  = '0;
    bus.Data_B  = '0;
    model_reset();
    #12 reset = 1'b0;
    @(posedge clk);
    #1;
    idle(2);

    // Single source streaming r1..r4.
    ready_a_low = 0;
    for (int n = 1; n <= 4; n++) begin
      bus.Valid_A = 1'b1;
      bus.Addr_A  = 5'(n);
      bus.Data_A  = 32'(n * 'h11);
      cycle();
    end
    idle(4);
    check("stream_ready_a_low", 64'(ready_a_low), 64'd0);

    // Continuous contention from reset, then a mid-stream reset with both buffers full.
    do_reset();
    na = 0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      bus.Valid_A = 1'b1;
      bus.Addr_A  = 5'd5;
      bus.Data_A  = 32'('hA0 + na);
      bus.Valid_B = 1'b1;
      bus.Addr_B  = 5'd6;
      bus.Data_B  = 32'('hB0 + nb);
      cycle();
      if (acc_a) na++;
      if (acc_b) nb++;
    end
    check("contention_busy", 64'(bus.Busy), 64'd1);
    do_reset();
    idle(4);

    // Same-register race: both accepted together, A issues first, B's value lands last.
    bus.Valid_A = 1'b1;
    bus.Addr_A  = 5'd7;
    bus.Data_A  = 32'hAAAA_AAAA;
    bus.Valid_B = 1'b1;
    bus.Addr_B  = 5'd7;
    bus.Data_B  = 32'hBBBB_BBBB;
    cycle();
    idle(4);
    check("race_r7", 64'(o_rf[7]), 64'h0000_0000_BBBB_BBBB);

    // Register 0 write is consumed and suppressed.
    bus.Valid_B = 1'b1;
    bus.Addr_B  = 5'd0;
    bus.Data_B  = 32'hDEAD_BEEF;
    cycle();
    idle(4);

    // Backpressure: A streams while B wins one grant; Ready_A drops for one cycle.
    do_reset();
    ready_a_low = 0;
    na = 0;
    nb = 0;
    for (int i = 0; i < 12 && na < 4; i++) begin
      bus.Valid_A = 1'b1;
      bus.Addr_A  = 5'(9 + na);
      bus.Data_A  = 32'h1000 + 32'(na);
      bus.Valid_B = (nb == 0);
      bus.Addr_B  = 5'd10;
      bus.Data_B  = 32'h2000;
      cycle();
      if (acc_a) na++;
      if (acc_b) nb++;
    end
    idle(4);
    check("bp_ready_a_low", 64'(ready_a_low), 64'd1);
    check("bp_r12", 64'(o_rf[12]), 64'h1003);

    // Random traffic; a refused offer is held stable until accepted.
    for (int i = 0; i < 400; i++) begin
      if (!(bus.Valid_A && !acc_a)) begin
        bus.Valid_A = ($urandom_range(0, 3) != 0);
        bus.Addr_A  = 5'($urandom_range(0, 31));
        bus.Data_A  = $urandom;
      end
      if (!(bus.Valid_B && !acc_b)) begin
        bus.Valid_B = ($urandom_range(0, 3) != 0);
        bus.Addr_B  = 5'($urandom_range(0, 31));
        bus.Data_B  = $urandom;
      end
      cycle();
    end
    idle(4);

    for (int i = 0; i < 32; i++) check($sformatf("rf_r%0d", i), 64'(o_rf[i]), 64'(m_rf[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
